// File: rtl/signed_result_decoder_pkg.sv
// Shared types and constants for the signed result decoder: controller
// states, default geometry and the double-dabble digit adjust constants.
package signed_result_decoder_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Default geometry: 6-bit two's-complement word, two BCD digits
    localparam int WIDTH_DEF  = 6;
    localparam int DIGITS_DEF = 2;

    // A BCD digit at or above this value overflows past 9 after a left
    // shift, so it is pre-corrected by adding BCD_ADJ_ADD before the shift
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Width of the conversion step counter for the default word width
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

    // Single-digit "if >= 5 add 3" correction
    function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
        logic [3:0] res;
        if (digit >= BCD_ADJ_THRESH) begin
            res = digit + BCD_ADJ_ADD;
        end else begin
            res = digit;
        end
        return res;
    endfunction

endpackage

// File: rtl/signed_result_decoder_bcd_add3_digit.sv
// Combinational double-dabble cell: one BCD digit is corrected by +3
// when it is 5 or more, so the following left shift carries correctly.
module bcd_add3_digit
    import signed_result_decoder_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Apply the >=5 / +3 correction to a single digit
    always_comb begin
        digit_o = bcd_adjust(digit_i);
    end

endmodule

// File: rtl/signed_result_decoder.sv
// Signed result decoder: takes a two's-complement result word, produces
// its sign, magnitude and a two-digit BCD rendering of the magnitude.
// The BCD conversion runs one shift-and-add-3 step per clock; results are
// held in registers and qualified by out_valid until the consumer takes them.
module signed_result_decoder
    import signed_result_decoder_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Diff,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             Sign,
    output logic [WIDTH-1:0] Magnitude,
    output logic [3:0]       Tens,
    output logic [3:0]       Ones,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic               sign_cap_q, sign_cap_d;
    logic [WIDTH-1:0]   mag_cap_q, mag_cap_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         ones_q, ones_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               out_valid_q, out_valid_d;

    logic               sign_in_s;
    logic [WIDTH-1:0]   mag_in_s;
    logic [BCD_W-1:0]   bcd_adj_s;
    logic [SR_W-1:0]    sr_full_s;
    logic [SR_W-1:0]    sr_shift_s;
    logic [BCD_W-1:0]   bcd_final_s;

    // Sign and magnitude of the incoming word; -2^(WIDTH-1) maps onto
    // its own bit pattern, which read as unsigned is the right magnitude
    always_comb begin
        sign_in_s = Diff[WIDTH-1];
        if (sign_in_s) begin
            mag_in_s = ~Diff + ONE_W;
        end else begin
            mag_in_s = Diff;
        end
    end

    // One correction cell per BCD digit of the shift register
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3_digit u_adj (
            .digit_i (sr_q[WIDTH + 4*g +: 4]),
            .digit_o (bcd_adj_s[4*g +: 4])
        );
    end

    // One double-dabble step: corrected digits plus binary part, shifted
    // left so the binary MSB enters the ones digit LSB
    always_comb begin
        sr_full_s   = {bcd_adj_s, sr_q[WIDTH-1:0]};
        sr_shift_s  = sr_full_s << 1;
        bcd_final_s = sr_shift_s[SR_W-1 -: BCD_W];
    end

    // Next-state and next-output logic for the IDLE/CONVERT/DONE controller
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        sign_cap_d = sign_cap_q;
        mag_cap_d  = mag_cap_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        tens_d     = tens_q;
        ones_d     = ones_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_cap_d = sign_in_s;
                    mag_cap_d  = mag_in_s;
                    sr_d       = {{BCD_W{1'b0}}, mag_in_s};
                    cnt_d      = {CNT_W{1'b0}};
                    state_d    = CONVERT;
                end else begin
                    state_d    = IDLE;
                end
            end
            CONVERT: begin
                sr_d  = sr_shift_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // Last step: publish the whole result on this edge
                    tens_d  = bcd_final_s[7:4];
                    ones_d  = bcd_final_s[3:0];
                    sign_d  = sign_cap_q;
                    mag_d   = mag_cap_q;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = DONE;
                end else begin
                    state_d = CONVERT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
                sr_d    = {SR_W{1'b0}};
            end
        endcase

        // Handshake and status flags follow the state being entered so
        // they come straight out of flops
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d == CONVERT);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous active-low reset
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            sr_q        <= {SR_W{1'b0}};
            sign_cap_q  <= 1'b0;
            mag_cap_q   <= {WIDTH{1'b0}};
            sign_q      <= 1'b0;
            mag_q       <= {WIDTH{1'b0}};
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            sign_cap_q  <= sign_cap_d;
            mag_cap_q   <= mag_cap_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign Busy      = busy_q;
    assign out_valid = out_valid_q;
    assign Sign      = sign_q;
    assign Magnitude = mag_q;
    assign Tens      = tens_q;
    assign Ones      = ones_q;

endmodule

// File: tb/tb_signed_result_decoder.sv
// Scoreboard bench for signed_result_decoder: the driver pushes the
// expected decode of every accepted word, the monitor pops and compares
// when a result appears and checks it stays stable while held.
module tb_signed_result_decoder;

    localparam int W       = 6;
    localparam int LATENCY = 6;

    typedef struct {
        int sign;
        int mag;
        int tens;
        int ones;
    } exp_t;

    logic         Clock;
    logic         Reset;
    logic [W-1:0] Diff;
    logic         in_valid;
    logic         in_ready;
    logic         Sign;
    logic [W-1:0] Magnitude;
    logic [3:0]   Tens;
    logic [3:0]   Ones;
    logic         out_valid;
    logic         out_ready;
    logic         Busy;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cnt  = 0;
    int   done_cnt = 0;
    bit   rr_random = 1'b0;
    bit   ready_val = 1'b1;
    exp_t exp_q[$];
    int   acc_q[$];
    int   rise_q[$];

    signed_result_decoder dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Diff      (Diff),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sign      (Sign),
        .Magnitude (Magnitude),
        .Tens      (Tens),
        .Ones      (Ones),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Busy      (Busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) cyc <= cyc + 1;

    // Reference decode: plain signed arithmetic and decimal division
    function automatic exp_t model(input logic [W-1:0] d);
        exp_t e;
        int   v;
        int   m;
        v = $signed(d);
        m = (v < 0) ? -v : v;
        e.sign = (v < 0) ? 1 : 0;
        e.mag  = m;
        e.tens = m / 10;
        e.ones = m % 10;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_result(input string tag, input exp_t e);
        chk({tag, "_sign"}, int'(Sign), e.sign);
        chk({tag, "_mag"},  int'(Magnitude), e.mag);
        chk({tag, "_tens"}, int'(Tens), e.tens);
        chk({tag, "_ones"}, int'(Ones), e.ones);
    endtask

    // Offer one word until accepted (bounded); record its expectation
    task automatic send(input logic [W-1:0] d);
        int n;
        n = 0;
        @(negedge Clock);
        Diff     = d;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(model(d));
            acc_q.push_back(cyc + 1);
            acc_cnt++;
            @(negedge Clock);
            in_valid = 1'b0;
            Diff     = W'($urandom);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (acc_cnt != done_cnt && n < 500) begin
            @(negedge Clock);
            n++;
        end
        chk({tag, "_drain"}, acc_cnt - done_cnt, 0);
    endtask

    // Consumer side: out_ready is either held or randomised
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge Clock);
            if (rr_random) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = ready_val;
            end
        end
    end

    // Monitor: compare on out_valid rise, check stability and status flags
    initial begin
        exp_t cur;
        bit   prev_ov;
        bit   outstanding;
        int   a;
        cur = '{0, 0, 0, 0};
        prev_ov = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            if (!Reset) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        a   = acc_q.pop_front();
                        chk("latency", cyc - a, LATENCY);
                        chk_result("result", cur);
                        rise_q.push_back(cyc);
                    end
                end else if (out_valid && prev_ov) begin
                    chk_result("hold", cur);
                end
                if (!out_valid && prev_ov) begin
                    done_cnt++;
                end
                outstanding = (acc_cnt != done_cnt);
                chk("in_ready", int'(in_ready), outstanding ? 0 : 1);
                chk("busy", int'(Busy), (outstanding && !out_valid) ? 1 : 0);
                prev_ov = out_valid;
            end
        end
    end

    // Stimulus: directed scenarios then randomized traffic
    initial begin
        int   base;
        int   n;
        exp_t z;
        z = '{0, 0, 0, 0};
        Reset    = 1'b0;
        Diff     = '0;
        in_valid = 1'b0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(Busy), 0);
        chk_result("rst", z);
        @(negedge Clock);
        Reset = 1'b1;

        // Single conversions incl. extremes and zero
        send(6'b111011);
        wait_idle("neg5");
        send(6'b100000);
        send(6'b011111);
        send(6'b000000);
        wait_idle("edges");

        // Backpressure: result held, new word refused until released
        ready_val = 1'b0;
        repeat (2) @(negedge Clock);
        send(6'd17);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge Clock);
            n++;
        end
        chk("bp_reach_done", int'(out_valid), 1);
        repeat (5) @(negedge Clock);
        Diff     = 6'b111101;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge Clock);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk_result("bp", '{0, 17, 1, 7});
        end
        ready_val = 1'b1;
        send(6'b111101);
        wait_idle("bp");

        // Asynchronous reset in the middle of a conversion
        send(6'd45);
        repeat (3) @(negedge Clock);
        #2;
        Reset = 1'b0;
        exp_q.delete();
        acc_q.delete();
        acc_cnt = done_cnt;
        #1;
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_busy", int'(Busy), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk_result("arst", z);
        @(negedge Clock);
        Reset = 1'b1;
        send(6'b110100);
        wait_idle("post_rst");

        // Back-to-back stream at full rate
        base = rise_q.size();
        send(6'b111111);
        send(6'd9);
        send(6'b101100);
        wait_idle("b2b");
        if (rise_q.size() >= base + 3) begin
            chk("b2b_spacing1", rise_q[base+1] - rise_q[base], W + 2);
            chk("b2b_spacing2", rise_q[base+2] - rise_q[base+1], W + 2);
        end else begin
            chk("b2b_count", rise_q.size() - base, 3);
        end

        // Randomized traffic with random consumer backpressure
        rr_random = 1'b1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            send(W'($urandom));
        end
        wait_idle("random");
        rr_random = 1'b0;
        repeat (3) @(negedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
